// File: rtl/dma_sync_fifo.sv
// Single-clock FIFO buffering DMA read-engine data for the write engine.
// First-word-fall-through output, registered occupancy/threshold flags, sticky error flags.
module dma_sync_fifo #(
   parameter int DATA_WIDTH    = 32,
   parameter int DEPTH         = 16,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 2,
   localparam int CW           = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  push_valid,
   output logic                  push_ready,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic                  pop_valid,
   input  logic                  pop_ready,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic [CW-1:0]         count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int          AW       = CW - 1;
   localparam logic [CW-1:0] ONE      = CW'(1);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]         wr_ptr;
   logic [CW-1:0]         rd_ptr;
   logic                  push_fire;
   logic                  pop_fire;

   // Status comes only from registered pointers/count, never from the handshake inputs.
   assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[CW-1] != rd_ptr[CW-1]);
   assign empty        = (wr_ptr == rd_ptr);
   assign push_ready   = ~full;
   assign pop_valid    = ~empty;
   assign almost_full  = (count >= AFULL_C);
   assign almost_empty = (count <= AEMPTY_C);

   assign push_fire = push_valid & push_ready;
   assign pop_fire  = pop_valid & pop_ready;

   assign pop_data = mem[rd_ptr[AW-1:0]];

   // NOTE: the storage array carries no reset; empty/full guard every read, so stale
   // contents are never observed and the array can map onto plain RAM cells.
   always_ff @(posedge clk) begin
      if (push_fire && !flush && !rst)
         mem[wr_ptr[AW-1:0]] <= push_data;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge values of the others regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         // Error flags record the attempt itself, so a flush does not mask or clear them.
         if (push_valid && full)
            overflow <= 1'b1;
         if (pop_ready && empty)
            underflow <= 1'b1;

         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push_fire)
               wr_ptr <= wr_ptr + ONE;
            if (pop_fire)
               rd_ptr <= rd_ptr + ONE;
            case ({push_fire, pop_fire})
               2'b10:   count <= count + ONE;
               2'b01:   count <= count - ONE;
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dma_sync_fifo.sv
// Scoreboard bench for dma_sync_fifo: a queue model predicts occupancy, flags and pop order.
module tb_dma_sync_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          push_valid;
   logic          push_ready;
   logic [DW-1:0] push_data;
   logic          pop_valid;
   logic          pop_ready;
   logic [DW-1:0] pop_data;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic          overflow;
   logic          underflow;

   dma_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .push_valid   (push_valid),
      .push_ready   (push_ready),
      .push_data    (push_data),
      .pop_valid    (pop_valid),
      .pop_ready    (pop_ready),
      .pop_data     (pop_data),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_errors = 0;
   int            m_count  = 0;
   logic          m_ovf    = 1'b0;
   logic          m_udf    = 1'b0;
   logic [DW-1:0] sb_q[$];

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic check_state(input string where);
      check({where, ":count"},        32'(count),        32'(m_count));
      check({where, ":full"},         32'(full),         32'(m_count == DEPTH));
      check({where, ":empty"},        32'(empty),        32'(m_count == 0));
      check({where, ":push_ready"},   32'(push_ready),   32'(m_count != DEPTH));
      check({where, ":pop_valid"},    32'(pop_valid),    32'(m_count != 0));
      check({where, ":almost_full"},  32'(almost_full),  32'(m_count >= DEPTH - 2));
      check({where, ":almost_empty"}, 32'(almost_empty), 32'(m_count <= 2));
      check({where, ":overflow"},     32'(overflow),     32'(m_ovf));
      check({where, ":underflow"},    32'(underflow),    32'(m_udf));
   endtask

   // One clock cycle: drive inputs, check the head against the scoreboard, advance the model.
   task automatic cycle(input string where, input logic pv, input logic [DW-1:0] pd,
                        input logic pr, input logic fl);
      logic push_acc;
      logic pop_acc;
      push_valid = pv;
      push_data  = pd;
      pop_ready  = pr;
      flush      = fl;
      push_acc   = pv && (m_count != DEPTH) && !fl;
      pop_acc    = pr && (m_count != 0) && !fl;
      if (pop_acc) begin
         if (sb_q.size() == 0) check({where, ":sb_underrun"}, 32'(1), 32'(0));
         else check({where, ":pop_data"}, pop_data, sb_q.pop_front());
      end
      if (push_acc) sb_q.push_back(pd);
      if (pv && m_count == DEPTH) m_ovf = 1'b1;
      if (pr && m_count == 0)     m_udf = 1'b1;
      @(posedge clk);
      #1;
      if (fl) begin
         m_count = 0;
         sb_q.delete();
      end else begin
         m_count = m_count + int'(push_acc) - int'(pop_acc);
      end
      push_valid = 1'b0;
      pop_ready  = 1'b0;
      flush      = 1'b0;
      check_state(where);
   endtask

   task automatic do_reset(input logic pv, input logic pr);
      rst        = 1'b1;
      push_valid = pv;
      pop_ready  = pr;
      push_data  = 32'h5555_5555;
      @(posedge clk);
      #1;
      rst        = 1'b0;
      push_valid = 1'b0;
      pop_ready  = 1'b0;
      m_count    = 0;
      m_ovf      = 1'b0;
      m_udf      = 1'b0;
      sb_q.delete();
      check_state("reset");
   endtask

   initial begin
      rst        = 1'b1;
      flush      = 1'b0;
      push_valid = 1'b0;
      push_data  = '0;
      pop_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_reset(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle("idle", 1'b0, '0, 1'b0, 1'b0);

      // Fill to full, one word per cycle.
      for (int i = 1; i <= DEPTH; i++) begin
         cycle("fill", 1'b1, DW'(i), 1'b0, 1'b0);
         if (i == 1) check("fwft_head", pop_data, 32'h0000_0001);
      end
      check("full_after_fill", 32'(full), 32'(1));

      // Push into a full FIFO, then drain completely.
      cycle("ovf", 1'b1, 32'h0000_DEAD, 1'b0, 1'b0);
      check("ovf_count_held", 32'(count), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0);
      check("drained_empty", 32'(empty), 32'(1));

      // Pop and push together on an empty FIFO: only the push lands.
      cycle("udf", 1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0);
      check("udf_flag", 32'(underflow), 32'(1));
      check("udf_head", pop_data, 32'hA5A5_A5A5);

      // Bring occupancy to 8, then stream through the pointer wrap.
      for (int i = 0; i < 7; i++) cycle("pre_wrap", 1'b1, 32'h1000 + DW'(i), 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) cycle("wrap", 1'b1, 32'h2000 + DW'(i), 1'b1, 1'b0);
      check("wrap_count", 32'(count), 32'(8));

      // Flush at count 5 with a concurrent push.
      for (int i = 0; i < 3; i++) cycle("to5", 1'b0, '0, 1'b1, 1'b0);
      cycle("flush", 1'b1, 32'h0000_0077, 1'b0, 1'b1);
      check("flush_count", 32'(count), 32'(0));
      check("flush_keeps_ovf", 32'(overflow), 32'(1));

      // Refill a little, then reset with a handshake in flight.
      for (int i = 0; i < 3; i++) cycle("post_flush", 1'b1, 32'h3000 + DW'(i), 1'b0, 1'b0);
      do_reset(1'b1, 1'b1);
      cycle("after_rst_push", 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
      cycle("after_rst_pop", 1'b0, '0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
